time_counter_hms: RTL and testbench

- Parametrised hours/minutes/seconds timekeeper. It succeeds the fixed 1 MHz minute/second counter.
- Adds the following:
  - an hours field
  - a configurable clock rate
  - up/down counting
  - pause
  - synchronous preset load
  - a 1-second tick strobe
  - an alarm compare
  - a countdown-expired flag
- Sits in the board-level utility layer. It drives display/scan logic and timeout supervision from the local system clock.

---
 rtl/time_pkg.sv | 39 +++
 rtl/tick_prescaler.sv | 56 +++++
 rtl/time_counter_hms.sv | 182 ++++++++++++++++++
 tb/tb_time_counter_hms.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
//------------------------------------------------------------------------------
// time_pkg
//
// Shared definitions for the hours/minutes/seconds timekeeping blocks.
//
//   SEC_MAX / MIN_MAX : last legal value of the seconds / minutes fields
//   SEC_W / MIN_W     : seconds / minutes field widths
//   HOUR_W            : hours field width (covers HOUR_MAX up to 31)
//   time_t            : packed {hour, min, sec} triple
//   sat_field()       : clamps a 6-bit preset to a field maximum
//   is_zero()         : true when a time value is 00:00:00
//------------------------------------------------------------------------------
package time_pkg;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } time_t;

    // Presets above the field maximum clamp to the maximum rather than wrap,
    // so a bad preset can never leave a field out of range.
    function automatic logic [5:0] sat_field(input logic [5:0] value,
                                             input logic [5:0] max_value);
        return (value > max_value) ? max_value : value;
    endfunction

    function automatic logic is_zero(input time_t t);
        return (t == '0);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
//------------------------------------------------------------------------------
// tick_prescaler
//
// Divides InClk down to one strobe per second. The counter runs 0..CLK_HZ-1
// and wraps, so the strobe period is exactly CLK_HZ enabled cycles.
// While InEnable is low the count holds and the strobe is suppressed;
// counting resumes from the held value. InClear restarts the count at 0 and
// overrides InEnable.
//
// Parameters:
//   CLK_HZ  : InClk frequency in Hz (divide ratio)
//   PRE_W   : counter width, derived from CLK_HZ
//
// Ports:
//   InClk      in   system clock
//   InReset    in   asynchronous active-low reset
//   InEnable   in   1 = count, 0 = hold
//   InClear    in   synchronous restart of the count at 0
//   OutSecEvt  out  combinational strobe, high in the last cycle of a second
//------------------------------------------------------------------------------
module tick_prescaler #(
    parameter int CLK_HZ = 1_000_000,
    parameter int PRE_W  = $clog2(CLK_HZ)
) (
    input  logic InClk,
    input  logic InReset,
    input  logic InEnable,
    input  logic InClear,
    output logic OutSecEvt
);

    localparam logic [PRE_W-1:0] LAST = PRE_W'(CLK_HZ - 1);

    logic [PRE_W-1:0] count;
    logic             at_last;

    assign at_last = (count == LAST);

    // The strobe is taken straight from the count so the field update lands
    // exactly one edge after the last prescaler cycle.
    assign OutSecEvt = InEnable && at_last;

    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples pre-edge values; blocking here would create ordering
    // dependent races between always_ff blocks.
    always_ff @(posedge InClk or negedge InReset) begin
        if (!InReset) begin
            count <= '0;
        end else if (InClear) begin
            count <= '0;
        end else if (InEnable) begin
            count <= at_last ? '0 : count + PRE_W'(1);
        end
    end

endmodule

// File: rtl/time_counter_hms.sv
//------------------------------------------------------------------------------
// time_counter_hms
//
// Hours/minutes/seconds timekeeper with up/down counting, pause, preset
// load, per-second tick strobe, alarm compare and countdown-expired flag.
//
// Parameters:
//   CLK_HZ    : InClk frequency; one field update every CLK_HZ enabled cycles
//   HOUR_MAX  : last hour value before wrap (1..31)
//   PRE_W     : prescaler width, derived
//
// Ports:
//   InClk        in   system clock
//   InReset      in   asynchronous active-low reset
//   InEnable     in   1 = run, 0 = pause (prescaler and fields hold)
//   InDir        in   1 = count up, 0 = count down
//   InLoad       in   one-cycle synchronous preset strobe
//   InLoadSec    in   preset seconds  (saturates at 59)
//   InLoadMin    in   preset minutes  (saturates at 59)
//   InLoadHour   in   preset hours    (saturates at HOUR_MAX)
//   InAlarmEn    in   alarm compare enable
//   InAlarmMin   in   alarm minute
//   InAlarmHour  in   alarm hour
//   OutSecond    out  seconds 0..59
//   OutMinute    out  minutes 0..59
//   OutHour      out  hours 0..HOUR_MAX
//   OutTick      out  one-cycle pulse on every field update
//   OutAlarm     out  one-cycle pulse on an update that lands on hh:mm:00
//   OutExpired   out  level, countdown has reached 00:00:00
//------------------------------------------------------------------------------
module time_counter_hms
    import time_pkg::*;
#(
    parameter int CLK_HZ   = 1_000_000,
    parameter int HOUR_MAX = 23,
    parameter int PRE_W    = $clog2(CLK_HZ)
) (
    input  logic              InClk,
    input  logic              InReset,
    input  logic              InEnable,
    input  logic              InDir,
    input  logic              InLoad,
    input  logic [SEC_W-1:0]  InLoadSec,
    input  logic [MIN_W-1:0]  InLoadMin,
    input  logic [HOUR_W-1:0] InLoadHour,
    input  logic              InAlarmEn,
    input  logic [MIN_W-1:0]  InAlarmMin,
    input  logic [HOUR_W-1:0] InAlarmHour,
    output logic [SEC_W-1:0]  OutSecond,
    output logic [MIN_W-1:0]  OutMinute,
    output logic [HOUR_W-1:0] OutHour,
    output logic              OutTick,
    output logic              OutAlarm,
    output logic              OutExpired
);

    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(MIN_MAX);
    localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX);

    time_t cur;        // registered time
    time_t nxt;        // time after one step in the current direction
    time_t preset;     // saturated load value

    logic sec_evt;
    logic at_zero;
    logic do_step;
    logic alarm_hit;

    logic tick_q;
    logic alarm_q;
    logic expired_q;

    //--------------------------------------------------------------------------
    // One-second strobe; a load restarts the second from zero.
    //--------------------------------------------------------------------------
    tick_prescaler #(
        .CLK_HZ (CLK_HZ),
        .PRE_W  (PRE_W)
    ) u_prescaler (
        .InClk     (InClk),
        .InReset   (InReset),
        .InEnable  (InEnable),
        .InClear   (InLoad),
        .OutSecEvt (sec_evt)
    );

    //--------------------------------------------------------------------------
    // Next-value cascade. Every field is range-checked before it is chosen,
    // so the register can only ever receive a legal value.
    //--------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        nxt = cur;
        if (InDir) begin
            if (cur.sec >= SEC_LAST) begin
                nxt.sec = '0;
                if (cur.min >= MIN_LAST) begin
                    nxt.min  = '0;
                    nxt.hour = (cur.hour >= HOUR_LAST) ? '0 : cur.hour + HOUR_W'(1);
                end else begin
                    nxt.min = cur.min + MIN_W'(1);
                end
            end else begin
                nxt.sec = cur.sec + SEC_W'(1);
            end
        end else begin
            // At 00:00:00 the step is suppressed below, so the hour
            // decrement can never underflow.
            if (cur.sec == '0) begin
                nxt.sec = SEC_LAST;
                if (cur.min == '0) begin
                    nxt.min  = MIN_LAST;
                    nxt.hour = (cur.hour == '0) ? '0 : cur.hour - HOUR_W'(1);
                end else begin
                    nxt.min = cur.min - MIN_W'(1);
                end
            end else begin
                nxt.sec = cur.sec - SEC_W'(1);
            end
        end
    end

    always_comb begin
        preset.sec  = sat_field(InLoadSec, SEC_LAST);
        preset.min  = sat_field(InLoadMin, MIN_LAST);
        preset.hour = (InLoadHour > HOUR_LAST) ? HOUR_LAST : InLoadHour;
    end

    assign at_zero = is_zero(cur);

    // A countdown parked at 00:00:00 swallows the strobe: no update, no tick.
    assign do_step = sec_evt && (InDir || !at_zero);

    // The alarm looks at the value being stepped into, so it can only fire
    // alongside a tick and only once per match; loads never reach it.
    assign alarm_hit = InAlarmEn
                    && (nxt.hour == InAlarmHour)
                    && (nxt.min  == InAlarmMin)
                    && (nxt.sec  == '0);

    //--------------------------------------------------------------------------
    // State registers. Priority: reset > load > second strobe.
    //--------------------------------------------------------------------------
    always_ff @(posedge InClk or negedge InReset) begin
        if (!InReset) begin
            cur       <= '0;
            tick_q    <= 1'b0;
            alarm_q   <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            tick_q  <= 1'b0;
            alarm_q <= 1'b0;
            if (InLoad) begin
                cur       <= preset;
                expired_q <= !InDir && is_zero(preset);
            end else begin
                if (do_step) begin
                    cur     <= nxt;
                    tick_q  <= 1'b1;
                    alarm_q <= alarm_hit;
                end
                // Counting up always clears the flag; counting down sets it
                // on the edge that lands on 00:00:00 (or finds it already there).
                if (InDir) begin
                    expired_q <= 1'b0;
                end else if (sec_evt && (at_zero || is_zero(nxt))) begin
                    expired_q <= 1'b1;
                end
            end
        end
    end

    assign OutSecond  = cur.sec;
    assign OutMinute  = cur.min;
    assign OutHour    = cur.hour;
    assign OutTick    = tick_q;
    assign OutAlarm   = alarm_q;
    assign OutExpired = expired_q;

endmodule

// File: tb/tb_time_counter_hms.sv
//------------------------------------------------------------------------------
// tb_time_counter_hms
//
// Directed bench for time_counter_hms at CLK_HZ=10, HOUR_MAX=23. Expected
// field values are queued as stimulus is applied and popped each time the
// DUT raises OutTick. Inputs are driven and outputs sampled on the falling
// edge, away from the active rising edge.
//------------------------------------------------------------------------------
module tb_time_counter_hms;

    localparam int CLK_HZ   = 10;
    localparam int HOUR_MAX = 23;

    logic       InClk;
    logic       InReset;
    logic       InEnable;
    logic       InDir;
    logic       InLoad;
    logic [5:0] InLoadSec;
    logic [5:0] InLoadMin;
    logic [4:0] InLoadHour;
    logic       InAlarmEn;
    logic [5:0] InAlarmMin;
    logic [4:0] InAlarmHour;
    logic [5:0] OutSecond;
    logic [5:0] OutMinute;
    logic [4:0] OutHour;
    logic       OutTick;
    logic       OutAlarm;
    logic       OutExpired;

    typedef struct {
        int hour;
        int min;
        int sec;
        int alarm;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    time_counter_hms #(
        .CLK_HZ   (CLK_HZ),
        .HOUR_MAX (HOUR_MAX)
    ) dut (
        .InClk       (InClk),
        .InReset     (InReset),
        .InEnable    (InEnable),
        .InDir       (InDir),
        .InLoad      (InLoad),
        .InLoadSec   (InLoadSec),
        .InLoadMin   (InLoadMin),
        .InLoadHour  (InLoadHour),
        .InAlarmEn   (InAlarmEn),
        .InAlarmMin  (InAlarmMin),
        .InAlarmHour (InAlarmHour),
        .OutSecond   (OutSecond),
        .OutMinute   (OutMinute),
        .OutHour     (OutHour),
        .OutTick     (OutTick),
        .OutAlarm    (OutAlarm),
        .OutExpired  (OutExpired)
    );

    initial InClk = 1'b0;
    always #5 InClk = ~InClk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge InClk);
    endtask

    task automatic push(input int h, input int m, input int s, input int a);
        exp_t e;
        e.hour  = h;
        e.min   = m;
        e.sec   = s;
        e.alarm = a;
        sb.push_back(e);
    endtask

    task automatic load(input int h, input int m, input int s);
        InLoadHour = 5'(h);
        InLoadMin  = 6'(m);
        InLoadSec  = 6'(s);
        InLoad     = 1'b1;
        step();
        InLoad     = 1'b0;
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, ".hour"}, 32'(OutHour),   32'(h));
        check({tag, ".min"},  32'(OutMinute), 32'(m));
        check({tag, ".sec"},  32'(OutSecond), 32'(s));
    endtask

    // Steps until OutTick is seen (bounded), then compares against the
    // oldest queued expectation.
    task automatic wait_tick(input string tag, input int budget, output int cycles);
        bit   got;
        exp_t e;
        got    = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            cycles++;
            if (OutTick === 1'b1) got = 1'b1;
        end
        check({tag, ".tick_seen"}, 32'(got), 32'd1);
        if (got) begin
            if (sb.size() == 0) begin
                check({tag, ".sb_nonempty"}, 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check_time(tag, e.hour, e.min, e.sec);
                check({tag, ".alarm"}, 32'(OutAlarm), 32'(e.alarm));
            end
        end
    endtask

    task automatic count_ticks(input int n, output int ticks);
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (OutTick === 1'b1) ticks++;
        end
    endtask

    initial begin
        int cyc;
        int ticks;

        InReset     = 1'b0;
        InEnable    = 1'b0;
        InDir       = 1'b1;
        InLoad      = 1'b0;
        InLoadSec   = '0;
        InLoadMin   = '0;
        InLoadHour  = '0;
        InAlarmEn   = 1'b0;
        InAlarmMin  = '0;
        InAlarmHour = '0;

        // ---- reset state ----
        step();
        step();
        check_time("reset", 0, 0, 0);
        check("reset.tick",    32'(OutTick),    32'd0);
        check("reset.alarm",   32'(OutAlarm),   32'd0);
        check("reset.expired", 32'(OutExpired), 32'd0);
        InReset = 1'b1;

        // ---- free-running up count: ten seconds in 100 cycles ----
        InEnable = 1'b1;
        InDir    = 1'b1;
        for (int i = 1; i <= 10; i++) push(0, 0, i, 0);
        for (int i = 0; i < 10; i++) begin
            wait_tick("up_run", CLK_HZ + 2, cyc);
            check("up_run.period", 32'(cyc), 32'(CLK_HZ));
        end
        check("up_run.second10", 32'(OutSecond), 32'd10);
        step();
        check("up_run.tick_width", 32'(OutTick), 32'd0);

        // ---- asynchronous reset mid-count ----
        step();
        step();
        #2;
        InReset = 1'b0;
        #1;
        check_time("async_rst", 0, 0, 0);
        check("async_rst.tick",    32'(OutTick),    32'd0);
        check("async_rst.expired", 32'(OutExpired), 32'd0);
        InEnable = 1'b0;
        step();
        InReset = 1'b1;

        // ---- hour rollover and minute carry ----
        load(23, 59, 58);
        check_time("load_2359", 23, 59, 58);
        check("load_2359.tick", 32'(OutTick), 32'd0);
        InEnable = 1'b1;
        push(23, 59, 59, 0);
        push(0, 0, 0, 0);
        wait_tick("roll_a", CLK_HZ + 2, cyc);
        wait_tick("roll_b", CLK_HZ + 2, cyc);
        check("roll.expired", 32'(OutExpired), 32'd0);
        load(0, 59, 59);
        push(1, 0, 0, 0);
        wait_tick("carry_hour", CLK_HZ + 2, cyc);

        // ---- countdown to expiry ----
        InDir = 1'b0;
        load(0, 0, 2);
        check("down_load.expired", 32'(OutExpired), 32'd0);
        push(0, 0, 1, 0);
        push(0, 0, 0, 0);
        wait_tick("down_a", CLK_HZ + 2, cyc);
        check("down_a.expired", 32'(OutExpired), 32'd0);
        wait_tick("down_b", CLK_HZ + 2, cyc);
        check("down_b.expired", 32'(OutExpired), 32'd1);
        count_ticks(50, ticks);
        check("expired_hold.ticks", 32'(ticks), 32'd0);
        check_time("expired_hold", 0, 0, 0);
        check("expired_hold.expired", 32'(OutExpired), 32'd1);
        InDir = 1'b1;
        step();
        check("dir_up.expired_clear", 32'(OutExpired), 32'd0);
        push(0, 0, 1, 0);
        wait_tick("dir_up", CLK_HZ + 2, cyc);

        // ---- pause mid-second ----
        for (int i = 0; i < 4; i++) step();
        InEnable = 1'b0;
        count_ticks(37, ticks);
        check("pause.ticks", 32'(ticks), 32'd0);
        check_time("pause", 0, 0, 1);
        InEnable = 1'b1;
        push(0, 0, 2, 0);
        wait_tick("resume", CLK_HZ + 2, cyc);
        check("resume.remaining", 32'(cyc), 32'(CLK_HZ - 4));

        // ---- saturating loads and prescaler restart ----
        load(7, 63, 61);
        check_time("sat_ms", 7, 59, 59);
        for (int i = 0; i < 4; i++) step();
        load(31, 0, 0);
        check_time("sat_h", 23, 0, 0);
        push(23, 0, 1, 0);
        wait_tick("restart", CLK_HZ + 2, cyc);
        check("restart.period", 32'(cyc), 32'(CLK_HZ));

        // ---- load coinciding with the second strobe ----
        for (int i = 0; i < CLK_HZ - 1; i++) step();
        load(5, 30, 20);
        check_time("load_evt", 5, 30, 20);
        check("load_evt.tick", 32'(OutTick), 32'd0);
        push(5, 30, 21, 0);
        wait_tick("load_evt_next", CLK_HZ + 2, cyc);
        check("load_evt.period", 32'(cyc), 32'(CLK_HZ));

        // ---- down-count borrow across the hour, and zero load ----
        InDir = 1'b0;
        load(1, 0, 0);
        push(0, 59, 59, 0);
        wait_tick("borrow", CLK_HZ + 2, cyc);
        load(0, 0, 0);
        check("zero_load.expired", 32'(OutExpired), 32'd1);
        check("zero_load.tick",    32'(OutTick),    32'd0);

        // ---- alarm ----
        InDir       = 1'b1;
        InAlarmHour = 5'd1;
        InAlarmMin  = 6'd0;
        InAlarmEn   = 1'b1;
        load(0, 59, 59);
        check("alarm_load.expired", 32'(OutExpired), 32'd0);
        check("alarm_load.alarm",   32'(OutAlarm),   32'd0);
        push(1, 0, 0, 1);
        wait_tick("alarm_hit", CLK_HZ + 2, cyc);
        step();
        check("alarm_hit.width", 32'(OutAlarm), 32'd0);
        push(1, 0, 1, 0);
        wait_tick("alarm_after", CLK_HZ + 2, cyc);

        InAlarmEn = 1'b0;
        load(0, 59, 59);
        push(1, 0, 0, 0);
        wait_tick("alarm_disabled", CLK_HZ + 2, cyc);

        InAlarmEn = 1'b1;
        load(1, 0, 0);
        check("alarm_on_load.alarm", 32'(OutAlarm), 32'd0);
        push(1, 0, 1, 0);
        wait_tick("alarm_on_load", CLK_HZ + 2, cyc);

        check("sb.empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
